// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_defines (package)
//  Brief    : Shared types and constants for the mem_arbiter slice: arbiter
//             state encoding, access-size codes, request payload record and
//             the data word returned on a watchdog timeout.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_defines;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IFU  = 2'd1,
        ARB_LSU  = 2'd2
    } arb_state;

    localparam logic [1:0]  SIZE_B = 2'd0;
    localparam logic [1:0]  SIZE_H = 2'd1;
    localparam logic [1:0]  SIZE_W = 2'd2;

    localparam logic [31:0] ARB_TIMEOUT_RDATA = 32'hDEADBEEF;

    // One captured memory request, exactly as it will be driven on mem_*
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } arb_req_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_req_slot.sv
`default_nettype none
// ============================================================================
//  Module   : arb_req_slot
//  Brief    : Pending flag plus payload register for one requesting master.
//             A request pulse is taken only when nothing is pending for this
//             master and it does not own the bus (its own response cycle
//             counts as free). Issue clears the pending flag.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_req_slot
    import arb_defines::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     i_req_valid,
    input  arb_req_t i_req,
    input  logic     i_in_flight,
    input  logic     i_issue,
    output logic     o_pend,
    output arb_req_t o_payload
);

    logic     r_pend;
    arb_req_t r_payload;
    logic     w_accept;

    assign w_accept  = i_req_valid && !r_pend && !i_in_flight;
    assign o_pend    = r_pend;
    assign o_payload = r_payload;

    // Capture a new request or retire the pending one when it is issued
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend    <= 1'b0;
            r_payload <= '0;
        end else if (w_accept) begin
            r_pend    <= 1'b1;
            r_payload <= i_req;
        end else if (i_issue) begin
            r_pend    <= 1'b0;
        end
    end

    // A pulse arriving while one is already pending or in flight is lost
    a_no_drop: assert property (@(posedge clock) disable iff (reset)
        i_req_valid |-> (!r_pend && !i_in_flight));

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Merges the core's instruction-fetch and load/store ports onto a
//             single-outstanding memory bus and routes each response back to
//             the master that issued it.
//  Options  : MEM_ARB_TIMEOUT_EN - adds a response watchdog and mem_err port.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import arb_defines::*;
#(
    parameter int PRIO_LSU       = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_ifu_reqValid,
    input  logic [31:0] io_ifu_addr,
    output logic        io_ifu_respValid,
    output logic [31:0] io_ifu_rdata,
    input  logic        io_lsu_reqValid,
    input  logic [31:0] io_lsu_addr,
    input  logic [1:0]  io_lsu_size,
    input  logic        io_lsu_wen,
    input  logic [31:0] io_lsu_wdata,
    input  logic [3:0]  io_lsu_wmask,
    output logic        io_lsu_respValid,
    output logic [31:0] io_lsu_rdata,
    output logic        mem_reqValid,
    output logic [31:0] mem_addr,
    output logic [1:0]  mem_size,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_respValid,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic        mem_err
`endif
);

    arb_state    r_state;
    arb_state    w_next_state;
    arb_req_t    w_ifu_req;
    arb_req_t    w_lsu_req;
    arb_req_t    w_ifu_payload;
    arb_req_t    w_lsu_payload;
    arb_req_t    w_bus;
    logic        w_pend_ifu;
    logic        w_pend_lsu;
    logic        w_pick_lsu;
    logic        w_issue;
    logic        w_timeout;
    logic        w_done;
    logic        w_ifu_deliver;
    logic        w_lsu_deliver;
    logic [31:0] w_resp_data;
    logic [31:0] r_ifu_rdata;
    logic [31:0] r_lsu_rdata;

    // Fetches are always full-word reads
    assign w_ifu_req = '{addr: io_ifu_addr, size: SIZE_W, wen: 1'b0,
                         wdata: 32'd0, wmask: 4'hF};
    assign w_lsu_req = '{addr: io_lsu_addr, size: io_lsu_size, wen: io_lsu_wen,
                         wdata: io_lsu_wdata, wmask: io_lsu_wmask};

    arb_req_slot u_ifu_slot (
        .clock       (clock),
        .reset       (reset),
        .i_req_valid (io_ifu_reqValid),
        .i_req       (w_ifu_req),
        .i_in_flight ((r_state == ARB_IFU) && !w_ifu_deliver),
        .i_issue     (w_issue && !w_pick_lsu),
        .o_pend      (w_pend_ifu),
        .o_payload   (w_ifu_payload)
    );

    arb_req_slot u_lsu_slot (
        .clock       (clock),
        .reset       (reset),
        .i_req_valid (io_lsu_reqValid),
        .i_req       (w_lsu_req),
        .i_in_flight ((r_state == ARB_LSU) && !w_lsu_deliver),
        .i_issue     (w_issue && w_pick_lsu),
        .o_pend      (w_pend_lsu),
        .o_payload   (w_lsu_payload)
    );

    assign w_pick_lsu    = w_pend_lsu && ((PRIO_LSU != 0) || !w_pend_ifu);
    assign w_issue       = (r_state == ARB_IDLE) && (w_pend_ifu || w_pend_lsu);
    assign w_done        = (r_state != ARB_IDLE) && (mem_respValid || w_timeout);
    assign w_ifu_deliver = (r_state == ARB_IFU) && w_done;
    assign w_lsu_deliver = (r_state == ARB_LSU) && w_done;
    // A real response always beats a coincident timeout
    assign w_resp_data   = mem_respValid ? mem_rdata : ARB_TIMEOUT_RDATA;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [c_CNT_W-1:0] r_wait_cnt;

    // Count cycles spent waiting for the outstanding response
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (w_issue) begin
            r_wait_cnt <= '0;
        end else if (r_state != ARB_IDLE) begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
        end
    end

    // Counter reads LAST in the TIMEOUT_CYCLES-th cycle after issue
    assign w_timeout = (r_state != ARB_IDLE) && (r_wait_cnt == c_CNT_LAST);
    assign mem_err   = w_timeout && !mem_respValid;
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: issue from idle, return to idle once the response lands
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_issue) begin
                    w_next_state = w_pick_lsu ? ARB_LSU : ARB_IFU;
                end
            end
            ARB_IFU, ARB_LSU: begin
                if (w_done) begin
                    w_next_state = ARB_IDLE;
                end
            end
            default: w_next_state = ARB_IDLE;
        endcase
    end

    // Outputs: one-cycle request pulse, payload held while in flight
    always_comb begin
        mem_reqValid     = 1'b0;
        w_bus            = '0;
        io_ifu_respValid = 1'b0;
        io_lsu_respValid = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_issue) begin
                    mem_reqValid = 1'b1;
                    w_bus        = w_pick_lsu ? w_lsu_payload : w_ifu_payload;
                end
            end
            ARB_IFU: begin
                w_bus            = w_ifu_payload;
                io_ifu_respValid = w_done;
            end
            ARB_LSU: begin
                w_bus            = w_lsu_payload;
                io_lsu_respValid = w_done;
            end
            default: ;
        endcase
    end

    assign mem_addr  = w_bus.addr;
    assign mem_size  = w_bus.size;
    assign mem_wen   = w_bus.wen;
    assign mem_wdata = w_bus.wdata;
    assign mem_wmask = w_bus.wmask;

    // Remember the last word returned to each master
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ifu_rdata <= 32'd0;
            r_lsu_rdata <= 32'd0;
        end else begin
            if (w_ifu_deliver) r_ifu_rdata <= w_resp_data;
            if (w_lsu_deliver) r_lsu_rdata <= w_resp_data;
        end
    end

    assign io_ifu_rdata = w_ifu_deliver ? w_resp_data : r_ifu_rdata;
    assign io_lsu_rdata = w_lsu_deliver ? w_resp_data : r_lsu_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter: directed scenarios followed
//             by randomized traffic, compared cycle by cycle against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int          PRIO = 1;
    localparam int          TOUT = 8;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit          TO_EN = 1'b1;
`else
    localparam bit          TO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_ifu_reqValid;
    logic [31:0] io_ifu_addr;
    logic        io_ifu_respValid;
    logic [31:0] io_ifu_rdata;
    logic        io_lsu_reqValid;
    logic [31:0] io_lsu_addr;
    logic [1:0]  io_lsu_size;
    logic        io_lsu_wen;
    logic [31:0] io_lsu_wdata;
    logic [3:0]  io_lsu_wmask;
    logic        io_lsu_respValid;
    logic [31:0] io_lsu_rdata;
    logic        mem_reqValid;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_respValid;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        mem_err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending request per master (0 = IFU, 1 = LSU),
    // the single outstanding transaction and the last word each master saw.
    bit          m_pend [2];
    mreq_t       m_pay  [2];
    bit          m_busy;
    int          m_owner;
    mreq_t       m_cur;
    int          m_age;
    logic [31:0] m_last [2];

    always #5 clock = ~clock;

    mem_arbiter #(.PRIO_LSU(PRIO), .TIMEOUT_CYCLES(TOUT)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_ifu_reqValid  (io_ifu_reqValid),
        .io_ifu_addr      (io_ifu_addr),
        .io_ifu_respValid (io_ifu_respValid),
        .io_ifu_rdata     (io_ifu_rdata),
        .io_lsu_reqValid  (io_lsu_reqValid),
        .io_lsu_addr      (io_lsu_addr),
        .io_lsu_size      (io_lsu_size),
        .io_lsu_wen       (io_lsu_wen),
        .io_lsu_wdata     (io_lsu_wdata),
        .io_lsu_wmask     (io_lsu_wmask),
        .io_lsu_respValid (io_lsu_respValid),
        .io_lsu_rdata     (io_lsu_rdata),
        .mem_reqValid     (mem_reqValid),
        .mem_addr         (mem_addr),
        .mem_size         (mem_size),
        .mem_wen          (mem_wen),
        .mem_wdata        (mem_wdata),
        .mem_wmask        (mem_wmask),
        .mem_respValid    (mem_respValid),
        .mem_rdata        (mem_rdata)
`ifdef MEM_ARB_TIMEOUT_EN
        ,
        .mem_err          (mem_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic mreq_t lsu_rec(input logic [31:0] a, input logic [1:0] s,
                                      input logic w, input logic [31:0] d,
                                      input logic [3:0] m);
        mreq_t r;
        r.addr = a; r.size = s; r.wen = w; r.wdata = d; r.wmask = m;
        return r;
    endfunction

    function automatic mreq_t ifu_rec(input logic [31:0] a);
        return lsu_rec(a, 2'd2, 1'b0, 32'd0, 4'hF);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 1'b0;
            m_pay[i]  = '0;
            m_last[i] = 32'd0;
        end
        m_busy  = 1'b0;
        m_owner = 0;
        m_cur   = '0;
        m_age   = 0;
    endfunction

    // Will the outstanding transaction complete this cycle, given mv?
    function automatic bit finishing(input bit mv);
        return m_busy && (mv || (TO_EN && m_age == TOUT));
    endfunction

    // One clock cycle: drive inputs, compare all outputs, advance the model.
    // Entered and left 1 time unit after a rising edge.
    task automatic step(input bit iv, input logic [31:0] ia, input bit lv,
                        input mreq_t lp, input bit mv, input logic [31:0] md);
        mreq_t e_bus;
        bit    e_req;
        bit    e_done [2];
        bit    fin;
        bit    acc_i;
        bit    acc_l;
        int    sel;
        io_ifu_reqValid = iv;
        io_ifu_addr     = ia;
        io_lsu_reqValid = lv;
        io_lsu_addr     = lp.addr;
        io_lsu_size     = lp.size;
        io_lsu_wen      = lp.wen;
        io_lsu_wdata    = lp.wdata;
        io_lsu_wmask    = lp.wmask;
        mem_respValid   = mv;
        mem_rdata       = md;
        #1;
        e_req     = 1'b0;
        e_bus     = '0;
        e_done[0] = 1'b0;
        e_done[1] = 1'b0;
        sel       = -1;
        fin       = finishing(mv);
        acc_i     = iv && !m_pend[0] && !(m_busy && m_owner == 0 && !fin);
        acc_l     = lv && !m_pend[1] && !(m_busy && m_owner == 1 && !fin);
        if (m_busy) begin
            e_bus = m_cur;
            if (fin) begin
                e_done[m_owner] = 1'b1;
                m_last[m_owner] = mv ? md : DEAD;
            end
        end else if (m_pend[0] || m_pend[1]) begin
            sel   = (m_pend[1] && (PRIO != 0 || !m_pend[0])) ? 1 : 0;
            e_req = 1'b1;
            e_bus = m_pay[sel];
        end
        chk("mem_reqValid",     32'(mem_reqValid),     32'(e_req));
        chk("mem_addr",         mem_addr,              e_bus.addr);
        chk("mem_size",         32'(mem_size),         32'(e_bus.size));
        chk("mem_wen",          32'(mem_wen),          32'(e_bus.wen));
        chk("mem_wdata",        mem_wdata,             e_bus.wdata);
        chk("mem_wmask",        32'(mem_wmask),        32'(e_bus.wmask));
        chk("io_ifu_respValid", 32'(io_ifu_respValid), 32'(e_done[0]));
        chk("io_lsu_respValid", 32'(io_lsu_respValid), 32'(e_done[1]));
        chk("io_ifu_rdata",     io_ifu_rdata,          m_last[0]);
        chk("io_lsu_rdata",     io_lsu_rdata,          m_last[1]);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("mem_err",          32'(mem_err),          32'(fin && !mv));
`endif
        if (fin) m_busy = 1'b0;
        if (sel >= 0) begin
            m_busy      = 1'b1;
            m_owner     = sel;
            m_cur       = m_pay[sel];
            m_pend[sel] = 1'b0;
            m_age       = 0;
        end
        if (m_busy) m_age++;
        if (acc_i) begin m_pend[0] = 1'b1; m_pay[0] = ifu_rec(ia); end
        if (acc_l) begin m_pend[1] = 1'b1; m_pay[1] = lp; end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, '0, 1'b0, 32'd0);
    endtask

    task automatic respond(input logic [31:0] d);
        step(1'b0, 32'd0, 1'b0, '0, 1'b1, d);
    endtask

    task automatic quiet_inputs();
        io_ifu_reqValid = 1'b0; io_ifu_addr  = '0;
        io_lsu_reqValid = 1'b0; io_lsu_addr  = '0; io_lsu_size = '0;
        io_lsu_wen      = 1'b0; io_lsu_wdata = '0; io_lsu_wmask = '0;
        mem_rdata       = 32'h1234_5678;
    endtask

    // Reset while a late memory response is presented; everything must read 0
    task automatic pulse_reset();
        reset = 1'b1;
        quiet_inputs();
        mem_respValid = 1'b1;
        #1;
        chk("rst mem_reqValid",     32'(mem_reqValid),     32'd0);
        chk("rst mem_addr",         mem_addr,              32'd0);
        chk("rst mem_wmask",        32'(mem_wmask),        32'd0);
        chk("rst io_ifu_respValid", 32'(io_ifu_respValid), 32'd0);
        chk("rst io_lsu_respValid", 32'(io_lsu_respValid), 32'd0);
        chk("rst io_ifu_rdata",     io_ifu_rdata,          32'd0);
        chk("rst io_lsu_rdata",     io_lsu_rdata,          32'd0);
        @(posedge clock);
        #1;
        reset         = 1'b0;
        mem_respValid = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        quiet_inputs();
        mem_respValid = 1'b0;
        reset         = 1'b1;
        @(posedge clock);
        #1;
        pulse_reset();

        // Fetch: issue next cycle, memory answers 3 cycles later
        step(1'b1, 32'h8000_0000, 1'b0, '0, 1'b0, 32'd0);
        idle(3);
        respond(32'h0000_0513);
        idle(1);

        // Byte store, payload must stay put until the response
        step(1'b0, 32'd0, 1'b1, lsu_rec(32'h100, 2'd0, 1'b1, 32'hAB, 4'h1), 1'b0, 32'd0);
        idle(4);
        respond(32'h0BAD_F00D);
        idle(1);

        // Simultaneous requests: priority order, one bubble between
        step(1'b1, 32'h8000_0004, 1'b1, lsu_rec(32'h200, 2'd2, 1'b0, 32'd0, 4'hF), 1'b0, 32'd0);
        idle(2);
        respond(32'h1111_2222);
        idle(2);
        respond(32'h3333_4444);
        idle(1);

        // Fetch pulse in the same cycle as the LSU response is not lost
        step(1'b0, 32'd0, 1'b1, lsu_rec(32'h300, 2'd1, 1'b0, 32'd0, 4'h3), 1'b0, 32'd0);
        idle(2);
        step(1'b1, 32'h8000_0008, 1'b0, '0, 1'b1, 32'h5555_6666);
        idle(1);
        respond(32'h7777_8888);
        idle(1);

        // Reset mid-transaction, then a late response must be ignored
        step(1'b1, 32'h8000_000C, 1'b0, '0, 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b0, '0, 1'b0, 32'd0);
        pulse_reset();
        idle(2);
        respond(32'h9999_AAAA);
        step(1'b1, 32'h8000_0010, 1'b0, '0, 1'b0, 32'd0);
        idle(1);
        respond(32'hCAFE_0001);
        idle(1);

`ifdef MEM_ARB_TIMEOUT_EN
        // No memory response at all: watchdog answers at issue + TOUT
        step(1'b1, 32'h8000_0014, 1'b0, '0, 1'b0, 32'd0);
        idle(TOUT + 3);
        step(1'b0, 32'd0, 1'b1, lsu_rec(32'h400, 2'd2, 1'b1, 32'h1, 4'hF), 1'b0, 32'd0);
        idle(TOUT + 2);
`endif

        // Randomized traffic, never offering a pulse that would be dropped
        for (int c = 0; c < 3000; c++) begin
            bit    mv;
            bit    iv;
            bit    lv;
            bit    fin;
            mreq_t lp;
            mv  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            fin = finishing(mv);
            iv  = ($urandom_range(0, 2) == 0) && !m_pend[0] &&
                  !(m_busy && m_owner == 0 && !fin);
            lv  = ($urandom_range(0, 2) == 0) && !m_pend[1] &&
                  !(m_busy && m_owner == 1 && !fin);
            lp  = lsu_rec($urandom, 2'($urandom_range(0, 2)), 1'($urandom),
                          $urandom, 4'($urandom));
            step(iv, $urandom, lv, lp, mv, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
